// File: rtl/mem_to_fifo_mq.sv
// Multi-queue SRAM replay reader: round-robin read issue, tag-routed responses,
// credit backpressure, infinite replay and per-queue done / underflow status.
//
// state  | meaning
// IDLE   | waiting for a q_start rising edge
// RUN    | replaying the window, eligible for grants
// DONE   | replay finished; q_done once in-flight reads drain
module mem_to_fifo_mq #(
    parameter int NUM_QUEUES         = 4,
    parameter int QID_BITS           = $clog2(NUM_QUEUES),
    parameter int MEM_ADDR_WIDTH     = 19,
    parameter int MEM_DATA_WIDTH     = 36,
    parameter int FIFO_DATA_WIDTH    = 2*MEM_DATA_WIDTH,
    parameter int REPLAY_COUNT_WIDTH = 32,
    parameter int TAG_DEPTH_BITS     = 4,
    parameter int CREDIT_MAX         = 16,
    parameter int CREDIT_BITS        = $clog2(CREDIT_MAX)+1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     sw_rst,
    input  logic                                     cal_done,
    output logic                                     mem_r_n,
    output logic [MEM_ADDR_WIDTH-1:0]                mem_ad_rd,
    input  logic                                     mem_rd_full,
    input  logic                                     mem_qr_valid,
    input  logic [MEM_DATA_WIDTH-1:0]                mem_qrl,
    input  logic [MEM_DATA_WIDTH-1:0]                mem_qrh,
    output logic [NUM_QUEUES-1:0]                    q_fifo_wr_en,
    output logic [NUM_QUEUES*FIFO_DATA_WIDTH-1:0]    q_fifo_data,
    input  logic [NUM_QUEUES-1:0]                    q_fifo_rd_en,
    input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0]     q_addr_low,
    input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0]     q_addr_high,
    input  logic [NUM_QUEUES*REPLAY_COUNT_WIDTH-1:0] q_replay_count,
    input  logic [NUM_QUEUES-1:0]                    q_start,
    input  logic [NUM_QUEUES-1:0]                    q_enable,
    output logic [NUM_QUEUES-1:0]                    q_done,
    output logic                                     err_tag_underflow
);

    localparam int TAG_DEPTH = 2**TAG_DEPTH_BITS;
    localparam logic [TAG_DEPTH_BITS:0] TAG_FULL  = (TAG_DEPTH_BITS+1)'(TAG_DEPTH);
    localparam logic [CREDIT_BITS-1:0]  CRED_FULL = CREDIT_BITS'(CREDIT_MAX);
    localparam logic [QID_BITS-1:0]     PTR_INIT  = QID_BITS'(NUM_QUEUES-1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} q_state_t;

    logic srst;
    assign srst = rst | sw_rst;

    q_state_t                      state_q   [NUM_QUEUES];
    q_state_t                      state_d   [NUM_QUEUES];
    logic [MEM_ADDR_WIDTH-1:0]     addr_q    [NUM_QUEUES];
    logic [MEM_ADDR_WIDTH-1:0]     addr_lo   [NUM_QUEUES];
    logic [MEM_ADDR_WIDTH-1:0]     addr_hi   [NUM_QUEUES];
    logic [REPLAY_COUNT_WIDTH-1:0] rpt_cnt   [NUM_QUEUES];
    logic [REPLAY_COUNT_WIDTH-1:0] cnt_q     [NUM_QUEUES];
    logic [CREDIT_BITS-1:0]        credit_q  [NUM_QUEUES];
    logic [TAG_DEPTH_BITS:0]       inflight_q[NUM_QUEUES];
    logic [NUM_QUEUES-1:0]         inf_q, start_prev, start_rise, eligible, issue, at_last, resp_dec;

    logic [QID_BITS-1:0]           ptr_q, grant_id;
    logic                          grant_vld;

    logic [QID_BITS-1:0]           tag_mem [TAG_DEPTH];
    logic [TAG_DEPTH_BITS-1:0]     tag_wr, tag_rd;
    logic [TAG_DEPTH_BITS:0]       tag_cnt;
    logic                          tag_pop;
    logic [QID_BITS-1:0]           resp_qid;

    for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_unpack
        assign addr_lo[gi] = q_addr_low[gi*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
        assign addr_hi[gi] = q_addr_high[gi*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
        assign rpt_cnt[gi] = q_replay_count[gi*REPLAY_COUNT_WIDTH +: REPLAY_COUNT_WIDTH];
    end

    assign start_rise = q_start & ~start_prev;
    assign tag_pop    = mem_qr_valid && (tag_cnt != '0);
    assign resp_qid   = tag_mem[tag_rd];

    always_comb begin
        eligible = '0;
        at_last  = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            at_last[i]  = (addr_q[i] == addr_hi[i] - MEM_ADDR_WIDTH'(1));
            eligible[i] = (state_q[i] == S_RUN) && q_enable[i] && (credit_q[i] != '0) &&
                          cal_done && !mem_rd_full && (tag_cnt != TAG_FULL);
        end
    end

    // Round-robin search starting one past the last granted queue.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_QUEUES) idx = idx - NUM_QUEUES;
            if (!grant_vld && eligible[idx]) begin
                grant_vld = 1'b1;
                grant_id  = QID_BITS'(idx);
            end
        end
    end

    always_comb begin
        issue    = '0;
        resp_dec = '0;
        if (grant_vld) issue[grant_id] = 1'b1;
        if (tag_pop)   resp_dec[resp_qid] = 1'b1;
    end

    always_comb begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                S_IDLE: if (start_rise[i])
                            state_d[i] = (addr_lo[i] >= addr_hi[i]) ? S_DONE : S_RUN;
                S_RUN:  if (!q_start[i])
                            state_d[i] = S_IDLE;
                        else if (issue[i] && at_last[i] && !inf_q[i] &&
                                 cnt_q[i] == REPLAY_COUNT_WIDTH'(1))
                            state_d[i] = S_DONE;
                S_DONE: if (!q_start[i]) state_d[i] = S_IDLE;
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    // Loaded even during reset so a held q_start does not re-arm on release.
    always_ff @(posedge clk) start_prev <= q_start;

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                state_q[i]    <= S_IDLE;
                addr_q[i]     <= '0;
                cnt_q[i]      <= '0;
                credit_q[i]   <= CRED_FULL;
                inflight_q[i] <= '0;
            end
            inf_q  <= '0;
            q_done <= '0;
            ptr_q  <= PTR_INIT;
        end else begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                state_q[i] <= state_d[i];
                if (state_q[i] == S_IDLE && start_rise[i]) begin
                    addr_q[i] <= addr_lo[i];
                    cnt_q[i]  <= rpt_cnt[i];
                    inf_q[i]  <= (rpt_cnt[i] == '0);
                end else if (issue[i]) begin
                    if (at_last[i]) begin
                        addr_q[i] <= addr_lo[i];
                        if (!inf_q[i]) cnt_q[i] <= cnt_q[i] - REPLAY_COUNT_WIDTH'(1);
                    end else begin
                        addr_q[i] <= addr_q[i] + MEM_ADDR_WIDTH'(1);
                    end
                end
                if (issue[i] && !q_fifo_rd_en[i])
                    credit_q[i] <= credit_q[i] - CREDIT_BITS'(1);
                else if (!issue[i] && q_fifo_rd_en[i] && credit_q[i] != CRED_FULL)
                    credit_q[i] <= credit_q[i] + CREDIT_BITS'(1);
                if (issue[i] && !resp_dec[i])
                    inflight_q[i] <= inflight_q[i] + 1'b1;
                else if (!issue[i] && resp_dec[i])
                    inflight_q[i] <= inflight_q[i] - 1'b1;
                q_done[i] <= (state_q[i] == S_DONE) && (state_d[i] == S_DONE) &&
                             (inflight_q[i] == '0);
            end
            if (grant_vld) ptr_q <= grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (grant_vld) tag_mem[tag_wr] <= grant_id;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            tag_wr  <= '0;
            tag_rd  <= '0;
            tag_cnt <= '0;
        end else begin
            if (grant_vld) tag_wr <= tag_wr + 1'b1;
            if (tag_pop)   tag_rd <= tag_rd + 1'b1;
            if (grant_vld && !tag_pop)      tag_cnt <= tag_cnt + 1'b1;
            else if (!grant_vld && tag_pop) tag_cnt <= tag_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            mem_r_n           <= 1'b1;
            mem_ad_rd         <= '0;
            q_fifo_wr_en      <= '0;
            q_fifo_data       <= '0;
            err_tag_underflow <= 1'b0;
        end else begin
            mem_r_n      <= !grant_vld;
            if (grant_vld) mem_ad_rd <= addr_q[grant_id];
            q_fifo_wr_en <= resp_dec;
            if (tag_pop)
                q_fifo_data[int'(resp_qid)*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH] <= {mem_qrh, mem_qrl};
            if (mem_qr_valid && tag_cnt == '0) err_tag_underflow <= 1'b1;
        end
    end

endmodule
